// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin scheduler sharing one UART tx line among byte requesters
// Framing: start, 8 data bits LSB first, optional even parity, stop.
module uart_tx_scheduler #(
  parameter int N_REQ        = 4,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1
) (
  input  logic                 clk_sis,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 tx,
  output logic                 busy,
  output logic [1:0]           grant_id,
  output logic                 frame_done
);
  localparam int            BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_PEN  = BW'(CLKS_PER_BIT - 2);
  localparam logic [1:0]    PTR_LAST  = 2'(N_REQ - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par;
  logic [1:0]    rr_ptr;

  logic [3:0]    valid_ext;
  logic [3:0]    ready_ext;
  logic [31:0]   data_ext;
  logic [1:0]    idx;
  logic [1:0]    winner;
  logic          found;
  logic [7:0]    win_byte;

  // Requester vectors are padded to four lanes so the search index is always 2 bits wide.
  always_comb begin
    valid_ext = '0;
    valid_ext[N_REQ-1:0] = req_valid;
    data_ext = '0;
    data_ext[8*N_REQ-1:0] = req_data;
    found  = 1'b0;
    winner = 2'd0;
    idx    = rr_ptr;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (idx == PTR_LAST) ? 2'd0 : idx + 2'd1;
      if (!found && valid_ext[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
    win_byte  = data_ext[{winner, 3'b000} +: 8];
    ready_ext = (!rst && state == IDLE && found) ? (4'b0001 << winner) : 4'b0000;
    req_ready = ready_ext[N_REQ-1:0];
  end

  always_ff @(posedge clk_sis) begin
    if (rst) begin
      state      <= IDLE;
      baud       <= '0;
      bit_cnt    <= 3'd0;
      shreg      <= 8'd0;
      par        <= 1'b0;
      rr_ptr     <= PTR_LAST;
      tx         <= 1'b1;
      busy       <= 1'b0;
      grant_id   <= 2'd0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      baud       <= baud + BW'(1);
      case (state)
        IDLE: begin
          baud <= '0;
          if (found) begin
            shreg    <= win_byte;
            par      <= ^win_byte;
            grant_id <= winner;
            rr_ptr   <= winner;
            tx       <= 1'b0;
            busy     <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          if (baud == BAUD_LAST) begin
            baud    <= '0;
            bit_cnt <= 3'd0;
            tx      <= shreg[0];
            state   <= DATA;
          end
        end
        DATA: begin
          // Counter wraps per bit so non-power-of-two bit periods stay exact.
          if (baud == BAUD_LAST) begin
            baud <= '0;
            if (bit_cnt == 3'd7) begin
              if (PARITY_EN != 0) begin
                tx    <= par;
                state <= PARITY;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= shreg[bit_cnt + 3'd1];
            end
          end
        end
        PARITY: begin
          if (baud == BAUD_LAST) begin
            baud  <= '0;
            tx    <= 1'b1;
            state <= STOP;
          end
        end
        STOP: begin
          // Raised one cycle early so the registered pulse lands in the last stop cycle.
          if (baud == BAUD_PEN) frame_done <= 1'b1;
          if (baud == BAUD_LAST) begin
            baud  <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - directed self-checking bench for uart_tx_scheduler
`timescale 1ns/1ps
module tb_uart_tx_scheduler;
  localparam int C = 4;

  logic        clk_sis = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = 4'b0000;
  logic [31:0] req_data = 32'h0;
  logic [3:0]  req_ready;
  logic        tx, busy, frame_done;
  logic [1:0]  grant_id;
  logic [3:0]  np_valid = 4'b0000;
  logic [31:0] np_data = 32'h0;
  logic [3:0]  np_ready;
  logic        np_tx, np_busy, np_done;
  logic [1:0]  np_grant;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  uart_tx_scheduler #(.N_REQ(4), .CLKS_PER_BIT(C), .PARITY_EN(1)) dut (
    .clk_sis(clk_sis), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx(tx), .busy(busy), .grant_id(grant_id), .frame_done(frame_done)
  );

  uart_tx_scheduler #(.N_REQ(4), .CLKS_PER_BIT(C), .PARITY_EN(0)) dut_np (
    .clk_sis(clk_sis), .rst(rst), .req_valid(np_valid), .req_data(np_data),
    .req_ready(np_ready), .tx(np_tx), .busy(np_busy), .grant_id(np_grant), .frame_done(np_done)
  );

  always #5 clk_sis = ~clk_sis;
  always @(posedge clk_sis) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  function automatic logic frame_bit(input logic [7:0] b, input int i, input bit pen);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[3'(i - 1)];
    if (i == 9 && pen) return ^b;
    return 1'b1;
  endfunction

  task automatic tick();
    @(negedge clk_sis);
    #1;
  endtask

  task automatic wait_accept(output int who, output int at);
    who = -1;
    at  = cyc;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (req_ready != 4'b0000) begin
        for (int i = 0; i < 4; i++) if (req_ready[i]) who = i;
        at = cyc;
        return;
      end
      @(negedge clk_sis);
    end
    n_cmp++; n_bad++;
    $display("FAIL accept_timeout got no req_ready want a strobe");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req_valid = 4'hF;
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx got %b want 1", tx); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", frame_done); end
    n_cmp++; if (grant_id !== 2'd0) begin n_bad++; $display("FAIL reset_grant got %0d want 0", grant_id); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready got %b want 0000", req_ready); end
    n_cmp++; if (np_tx !== 1'b1) begin n_bad++; $display("FAIL reset_np_tx got %b want 1", np_tx); end
    req_valid = 4'b0000;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_byte();
    int who, t0;
    logic exp;
    req_data = 32'h0000_00A5;
    req_valid = 4'b0001;
    wait_accept(who, t0);
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL single_ready got %b want 0001", req_ready); end
    for (int n = 1; n <= 44; n++) begin
      tick();
      if (n == 1) begin
        req_valid = 4'b0000;
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL single_ready_pulse got %b want 0000", req_ready); end
        n_cmp++; if (grant_id !== 2'd0) begin n_bad++; $display("FAIL single_grant got %0d want 0", grant_id); end
      end
      exp = frame_bit(8'hA5, (n - 1) / C, 1'b1);
      n_cmp++; if (tx !== exp) begin n_bad++; $display("FAIL single_tx n=%0d got %b want %b", n, tx, exp); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy n=%0d got %b want 1", n, busy); end
      n_cmp++; if (frame_done !== (n == 44)) begin n_bad++; $display("FAIL single_done n=%0d got %b want %b", n, frame_done, n == 44); end
    end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_end got %b want 0", busy); end
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL single_tx_end got %b want 1", tx); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL single_done_end got %b want 0", frame_done); end
  endtask

  task automatic test_round_robin();
    logic [7:0] src_byte [4];
    int exp_id [5];
    int who, t, tprev;
    logic [7:0] rx;
    src_byte = '{8'h81, 8'h0F, 8'h5A, 8'hC3};
    exp_id = '{0, 1, 2, 3, 0};
    req_data = {src_byte[3], src_byte[2], src_byte[1], src_byte[0]};
    req_valid = 4'hF;
    do_reset();
    tprev = 0;
    for (int f = 0; f < 5; f++) begin
      wait_accept(who, t);
      n_cmp++; if (req_ready !== 4'(1 << exp_id[f])) begin n_bad++; $display("FAIL rr_ready f=%0d got %b want id %0d", f, req_ready, exp_id[f]); end
      if (f > 0) begin
        n_cmp++; if (t - tprev != 45) begin n_bad++; $display("FAIL rr_period f=%0d got %0d want 45", f, t - tprev); end
      end
      tprev = t;
      rx = 8'h00;
      for (int n = 1; n <= 44; n++) begin
        tick();
        if (n == 1) begin
          n_cmp++; if (grant_id !== 2'(exp_id[f])) begin n_bad++; $display("FAIL rr_grant f=%0d got %0d want %0d", f, grant_id, exp_id[f]); end
        end
        if ((n - 1) % C == 1 && (n - 1) / C >= 1 && (n - 1) / C <= 8) rx[3'((n - 1) / C - 1)] = tx;
      end
      n_cmp++; if (rx !== src_byte[exp_id[f]]) begin n_bad++; $display("FAIL rr_byte f=%0d got %h want %h", f, rx, src_byte[exp_id[f]]); end
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_alternate();
    int exp_id [4];
    int who, t;
    exp_id = '{1, 3, 1, 3};
    req_data = 32'h3300_1100;
    req_valid = 4'b1010;
    do_reset();
    for (int f = 0; f < 4; f++) begin
      wait_accept(who, t);
      n_cmp++; if (who != exp_id[f]) begin n_bad++; $display("FAIL alt_grant f=%0d got %0d want %0d", f, who, exp_id[f]); end
      for (int n = 1; n <= 44; n++) tick();
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_parity_bit();
    int who, t;
    req_data = 32'h0000_0007;
    req_valid = 4'b0001;
    wait_accept(who, t);
    for (int n = 1; n <= 44; n++) begin
      tick();
      if (n == 1) req_valid = 4'b0000;
      if (n >= 33 && n <= 36) begin
        n_cmp++; if (tx !== 1'b0) begin n_bad++; $display("FAIL par_bit7 n=%0d got %b want 0", n, tx); end
      end
      if (n >= 37 && n <= 40) begin
        n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL par_bit n=%0d got %b want 1", n, tx); end
      end
    end
    n_cmp++; if (frame_done !== 1'b1) begin n_bad++; $display("FAIL par_done got %b want 1", frame_done); end
  endtask

  task automatic test_no_parity();
    int k;
    np_data = 32'h0000_0007;
    np_valid = 4'b0001;
    k = 0;
    #1;
    while (np_ready == 4'b0000 && k < 100) begin
      tick();
      k++;
    end
    n_cmp++; if (np_ready !== 4'b0001) begin n_bad++; $display("FAIL np_ready got %b want 0001", np_ready); end
    for (int n = 1; n <= 41; n++) begin
      tick();
      if (n == 1) np_valid = 4'b0000;
      if (n >= 33 && n <= 36) begin
        n_cmp++; if (np_tx !== 1'b0) begin n_bad++; $display("FAIL np_bit7 n=%0d got %b want 0", n, np_tx); end
      end
      if (n >= 37 && n <= 40) begin
        n_cmp++; if (np_tx !== 1'b1) begin n_bad++; $display("FAIL np_stop n=%0d got %b want 1", n, np_tx); end
      end
      n_cmp++; if (np_done !== (n == 40)) begin n_bad++; $display("FAIL np_done n=%0d got %b want %b", n, np_done, n == 40); end
    end
    n_cmp++; if (np_busy !== 1'b0) begin n_bad++; $display("FAIL np_busy_end got %b want 0", np_busy); end
  endtask

  task automatic test_reset_mid_frame();
    int who, t;
    req_data = 32'h0000_0000;
    req_valid = 4'b0001;
    wait_accept(who, t);
    for (int n = 1; n <= 21; n++) begin
      tick();
      if (n == 1) req_valid = 4'b0000;
    end
    n_cmp++; if (tx !== 1'b0) begin n_bad++; $display("FAIL mid_tx_before got %b want 0", tx); end
    rst = 1'b1;
    tick();
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL mid_tx got %b want 1", tx); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy got %b want 0", busy); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL mid_done got %b want 0", frame_done); end
    rst = 1'b0;
    req_data = 32'h005A_0000;
    req_valid = 4'b0100;
    wait_accept(who, t);
    n_cmp++; if (who != 2) begin n_bad++; $display("FAIL mid_winner got %0d want 2", who); end
    tick();
    req_valid = 4'b0000;
    n_cmp++; if (grant_id !== 2'd2) begin n_bad++; $display("FAIL mid_grant got %0d want 2", grant_id); end
    for (int n = 2; n <= 44; n++) tick();
  endtask

  task automatic test_pulse_while_busy();
    int who, t;
    req_data = 32'h0000_003C;
    req_valid = 4'b0001;
    wait_accept(who, t);
    for (int n = 1; n <= 44; n++) begin
      tick();
      if (n == 1) req_valid = 4'b0000;
      if (n == 10) begin
        req_valid = 4'b0010;
        #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL pulse_ready got %b want 0000", req_ready); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL pulse_busy got %b want 1", busy); end
      end
      if (n == 11) req_valid = 4'b0000;
    end
    for (int n = 45; n <= 64; n++) begin
      tick();
      n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL pulse_idle_ready n=%0d got %b want 0000", n, req_ready); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL pulse_idle_busy n=%0d got %b want 0", n, busy); end
      n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL pulse_idle_tx n=%0d got %b want 1", n, tx); end
    end
    n_cmp++; if (grant_id !== 2'd0) begin n_bad++; $display("FAIL pulse_grant got %0d want 0", grant_id); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_round_robin();
    test_alternate();
    test_parity_bit();
    test_no_parity();
    test_reset_mid_frame();
    test_pulse_while_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares one UART serial transmit line among up to four byte requesters. Each requester offers one byte per valid/ready handshake. The scheduler picks a winner, latches its byte and sequences the full frame on `tx` with an internal bit-period counter: start, 8 data bits LSB first, even parity, stop. It sits between the system-side byte producers and the UART link toward the peer UART, and replaces per-source transmitters.

## Interface
- `N_REQ`, default 4: number of requesters, legal range 2..4.
- `CLKS_PER_BIT`, default 16: `clk_sis` cycles per serial bit, legal range ≥2.
- `PARITY_EN`, default 1: 1 inserts the parity bit; 0 omits it.
- `clk_sis`  in  1: system clock. This is the only clock.
- `rst`  in  1: reset, synchronous and active-high.
- `req_valid`  in  N_REQ: requester i has a byte to send.
- `req_data`  in  8*N_REQ: byte of requester i, on bits [8i+7:8i].
- `req_ready`  out  N_REQ: one-hot accept strobe. Combinational.
- `tx`  out  1: serial line. Registered. Idles high.
- `busy`  out  1: high while a frame is on the line. Registered.
- `grant_id`  out  2: index of the requester that owns the current or last frame. Registered.
- `frame_done`  out  1: one-cycle pulse in the last stop-bit cycle. Registered.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - If any `req_valid` bit is set, the winner is the first set bit searching upward from `rr_ptr+1`, wrapping modulo N_REQ.
  - `req_ready[winner]` = 1 in that cycle, and the transfer occurs.
  - The byte is latched into `shreg`, `grant_id` <= winner, `rr_ptr` <= winner, state <= START.
  - `req_ready` is 0 in every other state and for non-winners.
- START: `tx`=0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - `tx`=`shreg[bit_cnt]`, with bit_cnt 0..7, each bit held CLKS_PER_BIT cycles.
  - After bit 7: go to PARITY if PARITY_EN, else STOP.
- PARITY: `tx` = XOR of the latched byte (even parity), held CLKS_PER_BIT cycles, then STOP.
- STOP:
  - `tx`=1 for CLKS_PER_BIT cycles.
  - `frame_done`=1 in the final cycle, then IDLE.
- `busy`=1 in START, DATA, PARITY and STOP; 0 in IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1, is cleared on every state change, and its width is clog2(CLKS_PER_BIT).
- bit_cnt is 3 bits and is cleared on entry to DATA.
- Requester rules:
  - A requester must hold `req_valid` and `req_data` stable until it sees `req_ready`.
  - Dropping `req_valid` before acceptance is legal and withdraws the request with no transfer.
  - `req_data` may change freely after acceptance; the frame uses the latched copy.
- Requests arriving during a frame wait; they are arbitrated in the first IDLE cycle after STOP.

## Timing
- Reset values:
  - `tx`=1, `busy`=0, `frame_done`=0, `grant_id`=0, `req_ready`=0.
  - State IDLE, `rr_ptr`=N_REQ-1, so requester 0 has first priority.
- Acceptance in cycle T puts `tx` low from T+1.
- The start bit occupies cycles T+1..T+C, where C=CLKS_PER_BIT.
- Data bit k occupies cycles T+1+(k+1)C .. T+(k+2)C.
- Parity occupies T+1+9C..T+10C. Stop occupies T+1+10C..T+11C, and `frame_done` is high in cycle T+11C.
- Without parity, every stop and done time moves 1C earlier.
- Earliest next acceptance is T+11C+1, so back-to-back frame period is 11C+1 cycles (10C+1 without parity).
- Reset asserted mid-frame:
  - Next cycle matches the reset values: `tx`=1, no `frame_done`, and the latched byte is discarded.
  - The requester is not re-served, because its byte was already accepted.
- Simultaneous requests are served in strict rotation. A continuously requesting source waits at most N_REQ-1 frames.
- `req_valid` rising in the same cycle as the STOP→IDLE edge is seen in IDLE the next cycle; no request is lost.

## Test plan
- Single byte, C=4, PARITY_EN=1:
  - Stimulus: `req_data[7:0]`=0xA5 with `req_valid[0]`=1.
  - Required: `req_ready[0]` pulses 1 cycle.
  - Required: `tx` per-bit sequence 0,1,0,1,0,0,1,0,1,0,1.
  - Required: `frame_done` at acceptance+44, `busy` high 44 cycles, `grant_id`=0.
- All four `req_valid` held high from reset:
  - Grants occur in order 0,1,2,3,0, each 45 cycles apart.
  - `tx` carries each source's byte.
- Only requesters 1 and 3 valid continuously: grants alternate 1,3,1,3 and no other index is granted.
- Byte 0x07 with PARITY_EN=1: parity bit = 1.
- Byte 0x07 with PARITY_EN=0: the frame is 10C long and `frame_done` is at acceptance+40.
- Reset after data bit 3 of a frame, then `req_valid[2]` asserted:
  - Cycle after reset: `tx`=1, `busy`=0, no `frame_done`.
  - Requester 2 is then served first after requester 0 priority is checked; if only requester 2 is valid, `grant_id`=2.
- `req_valid[1]` pulsed for 1 cycle while busy: no grant and no `req_ready[1]`; the line stays idle after the current frame.
